d_latch: RTL and testbench

- Clock-synchronous emulation of a WIDTH-bit D latch with an active-high enable `c`.
- While `c`=1 the output tracks `d`; while `c`=0 the output holds the last captured value.
- Used as a glitch-free, timing-analysable replacement for a level-sensitive latch in datapath holding registers.
- Also provides status outputs: capture-valid and a latch-close pulse.

---
 rtl/d_latch.sv | 51 +++++
 tb/tb_d_latch.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/d_latch.sv
// Clock-synchronous emulation of a WIDTH-bit D latch with capture-valid and close-pulse status.
// Optional D_LATCH_TRANSPARENT_EN: q passes d combinationally while c is high.
module d_latch #(
   parameter int               WIDTH   = 4,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   input  logic             c,
   output logic [WIDTH-1:0] q,
   output logic             q_valid,
   output logic             close_pulse
);

   logic [WIDTH-1:0] q_reg;
   logic             c_q;
   logic             valid_reg;
   logic             pulse_reg;

   // d is only sampled while open, so X on a closed latch never reaches q_reg.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_reg <= RST_VAL;
      end else if (c) begin
         q_reg <= d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         c_q       <= 1'b0;
         valid_reg <= 1'b0;
         pulse_reg <= 1'b0;
      end else begin
         c_q       <= c;
         valid_reg <= valid_reg | c;
         pulse_reg <= c_q & ~c;
      end
   end

`ifdef D_LATCH_TRANSPARENT_EN
   assign q = c ? d : q_reg;
`else
   assign q = q_reg;
`endif

   assign q_valid     = valid_reg;
   assign close_pulse = pulse_reg;

endmodule

// File: tb/tb_d_latch.sv
// Self-checking bench for d_latch: directed sequences plus random c/d against a history-based model.
module tb_d_latch;

   localparam int WIDTH = 4;
   localparam logic [WIDTH-1:0] RST_VAL = '0;

   logic             clk;
   logic             rst_n;
   logic [WIDTH-1:0] d;
   logic             c;
   logic [WIDTH-1:0] q;
   logic             q_valid;
   logic             close_pulse;

   int checks = 0;
   int errors = 0;

   // Values of c and d seen at every rising edge since the last reset.
   logic             hist_c[$];
   logic [WIDTH-1:0] hist_d[$];

   d_latch #(.WIDTH(WIDTH), .RST_VAL(RST_VAL)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .d           (d),
      .c           (c),
      .q           (q),
      .q_valid     (q_valid),
      .close_pulse (close_pulse)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Latch output is the most recent d sampled while open, else the reset value.
   function automatic logic [WIDTH-1:0] model_q();
      for (int i = hist_c.size() - 1; i >= 0; i--)
         if (hist_c[i]) return hist_d[i];
      return RST_VAL;
   endfunction

   function automatic logic model_valid();
      foreach (hist_c[i])
         if (hist_c[i]) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic model_pulse();
      int n = hist_c.size();
      if (n < 2) return 1'b0;
      return hist_c[n-2] && !hist_c[n-1];
   endfunction

   task automatic check_all(input string where);
      chk({where, ":q"}, 32'(q), 32'(model_q()));
      chk({where, ":q_valid"}, 32'(q_valid), 32'(model_valid()));
      chk({where, ":close_pulse"}, 32'(close_pulse), 32'(model_pulse()));
   endtask

   task automatic step(input logic [WIDTH-1:0] dv, input logic cv, input string where);
      @(negedge clk);
      d = dv;
      c = cv;
      @(posedge clk);
      hist_c.push_back(cv);
      hist_d.push_back(dv);
      #1;
      check_all(where);
   endtask

   task automatic async_reset();
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      hist_c.delete();
      hist_d.delete();
      chk("rst:q", 32'(q), 32'(RST_VAL));
      chk("rst:q_valid", 32'(q_valid), 32'(0));
      chk("rst:close_pulse", 32'(close_pulse), 32'(0));
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   int pulses_seen;

   initial begin
      rst_n = 1'b0;
      d     = '0;
      c     = 1'b0;
      #1;
      chk("init:q", 32'(q), 32'(RST_VAL));
      chk("init:q_valid", 32'(q_valid), 32'(0));
      chk("init:close_pulse", 32'(close_pulse), 32'(0));
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 10; i++) step(4'b1111, 1'b0, "closed");
      chk("closed_q_const", 32'(q), 32'(4'b0000));

      step(4'b1111, 1'b1, "open1");
      chk("open1_q_const", 32'(q), 32'(4'b1111));
      chk("open1_valid_const", 32'(q_valid), 32'(1));
      step(4'b1100, 1'b1, "open2");
      chk("open2_q_const", 32'(q), 32'(4'b1100));

      step(4'b1100, 1'b0, "close");
      chk("close_pulse_hi", 32'(close_pulse), 32'(1));
      step(4'b0011, 1'b0, "hold");
      chk("hold_q_const", 32'(q), 32'(4'b1100));
      chk("close_pulse_lo", 32'(close_pulse), 32'(0));

      pulses_seen = 0;
      for (int ph = 0; ph < 4; ph++)
         for (int i = 0; i < 10; i++) begin
            step(4'b1100, (ph % 2) == 1, "toggle");
            if (close_pulse) pulses_seen++;
         end
      chk("toggle_pulse_count", 32'(pulses_seen), 32'(1));

      // Single-cycle low window and fast toggling at edge granularity.
      step(4'b0101, 1'b1, "short");
      step(4'b1001, 1'b0, "short");
      step(4'b0110, 1'b1, "short");
      step(4'b0110, 1'b1, "short");

      async_reset();
      step(4'b1010, 1'b1, "post_rst");
      chk("post_rst_q_const", 32'(q), 32'(4'b1010));

`ifdef D_LATCH_TRANSPARENT_EN
      #2 d = 4'b0111;
      #1 chk("transp_mid", 32'(q), 32'(4'b0111));
      step(4'b0001, 1'b0, "transp_close");
      chk("transp_hold", 32'(q), 32'(4'b1010));
`endif

      for (int i = 0; i < 300; i++) begin
         if (i == 150) async_reset();
         step(WIDTH'($urandom), ($urandom_range(0, 2) != 0), "rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
